frontpanel_scanner: RTL and testbench
=====================================

Name: frontpanel_scanner

Overview:
Parametrised, time-multiplexed LED scanner for the front panel. It drives NCOLORS channels of WIDTH lamp bits through NLEDS shared anode pins and one-hot group commons. Compared with the fixed 3×12/6-pin panel driver, it adds:
- a clock prescaler instead of a dedicated refresh clock,
- a blanking interval between groups to suppress ghosting,
- a frame-coherent snapshot of the lamp data,
- optional PWM dimming.

It sits between the CPU register/state outputs and the panel pins.

Parameters:
NCOLORS, 3, number of colour channels (channel 0 = green, 1 = red, 2 = yellow on the current panel)
WIDTH, 12, lamp bits per channel; must be a multiple of NLEDS
NLEDS, 6, shared anode pins per group
PRESCALE, 1024, CLK cycles per scan tick (>=1)
BLANK_TICKS, 1, ticks with all commons off before each group (>=1)
ON_TICKS, 4, ticks a group is driven (>=1)

Ports:
CLK  input  1  system clock
RESET  input  1  synchronous active-high reset
DATA  input  NCOLORS*WIDTH  lamp bits; channel c at DATA[c*WIDTH +: WIDTH]
BRIGHT  input  4  brightness, 0 = off, 15 = full (used only with FP_DIMMING_EN)
COMMON  output  NGROUPS  one-hot group common enables, NGROUPS = NCOLORS*WIDTH/NLEDS
PLED  output  NLEDS  shared anode drives
FRAME  output  1  one-cycle pulse at each snapshot capture

Behaviour:
- Interface is fixed: one clock (CLK); RESET is synchronous and active-high.
- Reset values: pre_cnt=0, cnt=0, group=0, state=BLANK, snapshot=0, pwm_cnt=0, COMMON=0, PLED=0, FRAME=0.
- RESET asserted mid-scan restores all reset values on the next edge; scanning restarts at group 0 with a BLANK slot.
- Prescaler:
  - pre_cnt counts 0..PRESCALE-1 and wraps.
  - tick=1 in the cycle where pre_cnt==PRESCALE-1.
  - PRESCALE=1 gives a tick every cycle.
- State machine (advances only on tick):
  - BLANK: if cnt==BLANK_TICKS-1, go to DRIVE with cnt=0; else cnt+1.
  - DRIVE: if cnt==ON_TICKS-1, go to BLANK with cnt=0 and group = (group==NGROUPS-1) ? 0 : group+1; else cnt+1.
- Snapshot:
  - On the edge taking BLANK->DRIVE with group==0, snapshot<=DATA and FRAME<=1 for exactly one cycle.
  - DATA changes at any other time have no visible effect until the next frame. No tearing within a frame.
- Group mapping: GPC = WIDTH/NLEDS, c = group/GPC, s = group%GPC.
  - Driven value: PLED[i] = snapshot[c*WIDTH + s*NLEDS + i].
  - Default parameters therefore scan green[5:0], green[11:6], red[5:0], red[11:6], yellow[5:0], yellow[11:6].
- Outputs are registered with one cycle of latency after the state, group and snapshot registers.
  - COMMON = one-hot(group) and PLED = mapped bits while in DRIVE.
  - COMMON = 0 and PLED = 0 while in BLANK.
- Invariants:
  - COMMON is never multi-hot.
  - COMMON and PLED are both zero for at least BLANK_TICKS*PRESCALE cycles between groups.
- Frame period = NGROUPS*(BLANK_TICKS+ON_TICKS)*PRESCALE cycles.
- Illegal parameters (WIDTH % NLEDS != 0, or any tick count or PRESCALE < 1) stop elaboration with a generate-time error.

Optional Feature:
FP_DIMMING_EN
- Defined:
  - A free-running 4-bit pwm_cnt increments every CLK, wraps 15->0, and is reset to 0.
  - During DRIVE, PLED[i] = mapped bit & (BRIGHT==15 | pwm_cnt < BRIGHT).
  - BRIGHT=0 gives PLED always 0.
  - COMMON timing is unchanged.
  - BRIGHT is sampled every cycle; no snapshot.
- Undefined: BRIGHT is ignored, pwm_cnt is not implemented, and PLED = mapped bit during DRIVE.

Test Plan:
1. Defaults except PRESCALE=1, BLANK_TICKS=1, ON_TICKS=2; release RESET.
   -> COMMON=6'b000001 after edge 2, held 2 cycles; 0 for 1 cycle; then 6'b000010. Pattern repeats with an 18-cycle frame. FRAME pulses every 18 cycles.
2. Same parameters, DATA={yellow=12'o7700, red=12'o0077, green=12'o5252}.
   -> PLED per group g0..g5 = 6'o52, 6'o52, 6'o77, 6'o00, 6'o00, 6'o77. PLED=0 in every BLANK cycle.
3. Change DATA mid-frame (during group 2).
   -> Groups 2-5 still show the old snapshot. New values appear from group 0 of the next frame, coincident with FRAME.
4. Assert RESET for one cycle while group 4 is in DRIVE.
   -> Next cycle: COMMON=0, PLED=0, group=0. Restart as in scenario 1; the snapshot is recaptured.
5. NCOLORS=2, WIDTH=8, NLEDS=4, PRESCALE=3.
   -> NGROUPS=4, COMMON width 4, tick every 3 cycles. Frame = 4*3*3 = 36 cycles. The mapping formula holds.
6. FP_DIMMING_EN, all DATA bits 1, BRIGHT=4.
   -> During DRIVE, PLED=6'o77 for exactly 4 of every 16 cycles. BRIGHT=15 gives always 6'o77; BRIGHT=0 gives always 0. COMMON is identical to scenario 1.

Source files
------------

// File: rtl/frontpanel_scanner_if.sv
// Front-panel scanner bus: lamp data and brightness in, panel pin drives and frame strobe out.
// master = CPU/register side, slave = scanner.
interface frontpanel_scanner_if #(
  parameter int unsigned NCOLORS = 3,
  parameter int unsigned WIDTH   = 12,
  parameter int unsigned NLEDS   = 6
) ();

  localparam int unsigned NGROUPS = NCOLORS * WIDTH / NLEDS;

  logic [NCOLORS*WIDTH-1:0] DATA;
  logic [3:0]               BRIGHT;
  logic [NGROUPS-1:0]       COMMON;
  logic [NLEDS-1:0]         PLED;
  logic                     FRAME;

  modport master (
    output DATA,
    output BRIGHT,
    input  COMMON,
    input  PLED,
    input  FRAME
  );

  modport slave (
    input  DATA,
    input  BRIGHT,
    output COMMON,
    output PLED,
    output FRAME
  );

endinterface

// File: rtl/frontpanel_scanner.sv
// Time-multiplexed front-panel LED scanner. Walks NGROUPS one-hot commons, each slot preceded by
// a blanking interval, driving NLEDS shared anodes from a snapshot of DATA taken once per frame.
// Optional PWM dimming via BRIGHT is compiled in when FP_DIMMING_EN is defined.
module frontpanel_scanner #(
  parameter int unsigned NCOLORS     = 3,
  parameter int unsigned WIDTH       = 12,
  parameter int unsigned NLEDS       = 6,
  parameter int unsigned PRESCALE    = 1024,
  parameter int unsigned BLANK_TICKS = 1,
  parameter int unsigned ON_TICKS    = 4
) (
  input logic                  CLK,
  input logic                  RESET,
  frontpanel_scanner_if.slave  bus
);

  localparam int unsigned NGROUPS  = NCOLORS * WIDTH / NLEDS;
  localparam int unsigned DW       = NCOLORS * WIDTH;
  localparam int unsigned GW       = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;
  localparam int unsigned MaxTicks = (BLANK_TICKS > ON_TICKS) ? BLANK_TICKS : ON_TICKS;
  localparam int unsigned CW       = (MaxTicks > 1) ? $clog2(MaxTicks) : 1;
  localparam int unsigned PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [PW-1:0] PreLast   = PW'(PRESCALE - 1);
  localparam logic [CW-1:0] BlankLast = CW'(BLANK_TICKS - 1);
  localparam logic [CW-1:0] OnLast    = CW'(ON_TICKS - 1);
  localparam logic [GW-1:0] GroupLast = GW'(NGROUPS - 1);

  if ((WIDTH % NLEDS) != 0 || PRESCALE < 1 || BLANK_TICKS < 1 || ON_TICKS < 1) begin : g_bad_params
    $error("frontpanel_scanner: illegal parameters");
  end

  typedef enum logic {StBlank, StDrive} state_e;

  logic [PW-1:0]    r_pre_cnt, w_pre_cnt_next;
  logic [CW-1:0]    r_cnt, w_cnt_next;
  logic [GW-1:0]    r_group, w_group_next;
  state_e           r_state, w_state_next;
  logic [DW-1:0]    r_snapshot;
  logic             w_tick;
  logic             w_capture;

  logic [NGROUPS-1:0] r_common, w_common;
  logic [NLEDS-1:0]   r_pled, w_mapped;
  logic               r_frame;
  logic               w_gate;
  int unsigned        w_base;

  // Prescaler, scan state, group and snapshot registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_pre_cnt  <= '0;
      r_cnt      <= '0;
      r_group    <= '0;
      r_state    <= StBlank;
      r_snapshot <= '0;
    end else begin
      r_pre_cnt <= w_pre_cnt_next;
      r_cnt     <= w_cnt_next;
      r_group   <= w_group_next;
      r_state   <= w_state_next;
      if (w_capture) begin
        r_snapshot <= bus.DATA;
      end
    end
  end

  // Next-state: the FSM only moves on a prescaler tick; capture on entering DRIVE of group 0.
  always_comb begin
    w_tick         = (r_pre_cnt == PreLast);
    w_pre_cnt_next = w_tick ? '0 : r_pre_cnt + 1'b1;
    w_cnt_next     = r_cnt;
    w_group_next   = r_group;
    w_state_next   = r_state;
    w_capture      = 1'b0;
    if (w_tick) begin
      unique case (r_state)
        StBlank: begin
          if (r_cnt == BlankLast) begin
            w_state_next = StDrive;
            w_cnt_next   = '0;
            w_capture    = (r_group == '0);
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end
        StDrive: begin
          if (r_cnt == OnLast) begin
            w_state_next = StBlank;
            w_cnt_next   = '0;
            w_group_next = (r_group == GroupLast) ? '0 : r_group + 1'b1;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end
        default: begin
          w_state_next = StBlank;
          w_cnt_next   = '0;
        end
      endcase
    end
  end

  // Group decode: channel c, slice s lands at c*WIDTH + s*NLEDS, which equals group*NLEDS
  // because WIDTH is a whole number of slices.
  always_comb begin
    w_common          = '0;
    w_common[r_group] = 1'b1;
    w_base            = 32'(r_group) * NLEDS;
    w_mapped          = r_snapshot[w_base +: NLEDS];
  end

`ifdef FP_DIMMING_EN
  logic [3:0] r_pwm_cnt;

  // Free-running PWM phase counter for brightness gating.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_pwm_cnt <= '0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 4'd1;
    end
  end

  assign w_gate = (bus.BRIGHT == 4'hF) || (r_pwm_cnt < bus.BRIGHT);
`else
  logic [3:0] w_unused_bright;
  assign w_unused_bright = bus.BRIGHT;
  assign w_gate          = 1'b1;
`endif

  // Pin drives: registered one cycle behind state/group/snapshot; dark during BLANK.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_common <= '0;
      r_pled   <= '0;
      r_frame  <= 1'b0;
    end else begin
      r_frame <= w_capture;
      if (r_state == StDrive) begin
        r_common <= w_common;
        r_pled   <= w_gate ? w_mapped : '0;
      end else begin
        r_common <= '0;
        r_pled   <= '0;
      end
    end
  end

  assign bus.COMMON = r_common;
  assign bus.PLED   = r_pled;
  assign bus.FRAME  = r_frame;

endmodule

// File: tb/tb_frontpanel_scanner.sv
// Directed bench for frontpanel_scanner: a 3x12/6 panel at PRESCALE=1 and a 2x8/4 panel at
// PRESCALE=3, both with BLANK_TICKS=1 and ON_TICKS=2, sharing clock and reset.
module tb_frontpanel_scanner;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  frontpanel_scanner_if #(.NCOLORS(3), .WIDTH(12), .NLEDS(6)) bus_a ();
  frontpanel_scanner_if #(.NCOLORS(2), .WIDTH(8), .NLEDS(4)) bus_b ();

  frontpanel_scanner #(
    .NCOLORS(3), .WIDTH(12), .NLEDS(6), .PRESCALE(1), .BLANK_TICKS(1), .ON_TICKS(2)
  ) u_dut_a (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus_a)
  );

  frontpanel_scanner #(
    .NCOLORS(2), .WIDTH(8), .NLEDS(4), .PRESCALE(3), .BLANK_TICKS(1), .ON_TICKS(2)
  ) u_dut_b (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus_b)
  );

  // {yellow, red, green}
  localparam logic [35:0] DataOld = {12'o7700, 12'o0077, 12'o5252};
  localparam logic [35:0] DataNew = {12'o1234, 12'o4567, 12'o7070};
  localparam logic [5:0]  TabOld [6] = '{6'o52, 6'o52, 6'o77, 6'o00, 6'o00, 6'o77};
  localparam logic [5:0]  TabNew [6] = '{6'o70, 6'o70, 6'o67, 6'o45, 6'o34, 6'o12};
  localparam logic [3:0]  TabB   [4] = '{4'h5, 4'hA, 4'hC, 4'h3};

  int          vectors = 0;
  int          miscompares = 0;
  int          n;
  logic [5:0]  exp_tab [6];
  logic [3:0]  bright;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk($sformatf("%s common_a", tag), 16'(bus_a.COMMON), 16'h0);
    chk($sformatf("%s pled_a", tag), 16'(bus_a.PLED), 16'h0);
    chk($sformatf("%s frame_a", tag), 16'(bus_a.FRAME), 16'h0);
    chk($sformatf("%s common_b", tag), 16'(bus_b.COMMON), 16'h0);
    chk($sformatf("%s pled_b", tag), 16'(bus_b.PLED), 16'h0);
    chk($sformatf("%s frame_b", tag), 16'(bus_b.FRAME), 16'h0);
  endtask

  // One clock; n counts edges since reset was released. Outputs after edge n show the scan
  // state reached after edge n-1.
  task automatic step();
    int         m, g, t, mb, gb;
    logic       drv_a, drv_b, fr_a, fr_b;
    logic [5:0] gate, e_com_a, e_pled_a;
    logic [3:0] e_com_b, e_pled_b;
    @(posedge clk);
    #1;
    n++;
    // Panel A: period 3 edges per group, 18 per frame, group 0 first lit after edge 2.
    fr_a  = ((n - 1) % 18) == 0;
    drv_a = 1'b0;
    g     = 0;
    if (n >= 2) begin
      m     = (n - 2) % 18;
      g     = m / 3;
      drv_a = (m % 3) != 2;
    end
`ifdef FP_DIMMING_EN
    gate = (bright == 4'hF || ((n - 1) % 16) < int'(bright)) ? 6'o77 : 6'o00;
`else
    gate = 6'o77;
`endif
    e_com_a  = drv_a ? 6'(1 << g) : 6'h0;
    e_pled_a = drv_a ? (exp_tab[g] & gate) : 6'h0;
    // Panel B: ticks at edges 3,6,9..; state after tick t is panel A's state after edge t.
    t     = (n - 1) / 3;
    drv_b = 1'b0;
    gb    = 0;
    if (t >= 1) begin
      mb    = (t - 1) % 12;
      gb    = mb / 3;
      drv_b = (mb % 3) != 2;
    end
    fr_b     = ((n % 3) == 0) && (((n / 3) % 12) == 1);
    e_com_b  = drv_b ? 4'(1 << gb) : 4'h0;
    e_pled_b = drv_b ? TabB[gb] : 4'h0;
    chk($sformatf("n%0d common_a", n), 16'(bus_a.COMMON), 16'(e_com_a));
    chk($sformatf("n%0d pled_a", n), 16'(bus_a.PLED), 16'(e_pled_a));
    chk($sformatf("n%0d frame_a", n), 16'(bus_a.FRAME), 16'(fr_a));
    chk($sformatf("n%0d common_b", n), 16'(bus_b.COMMON), 16'(e_com_b));
    chk($sformatf("n%0d pled_b", n), 16'(bus_b.PLED), 16'(e_pled_b));
    chk($sformatf("n%0d frame_b", n), 16'(bus_b.FRAME), 16'(fr_b));
  endtask

  initial begin
    rst           = 1'b1;
    bright        = 4'hF;
    bus_a.DATA    = DataOld;
    bus_a.BRIGHT  = bright;
    bus_b.DATA    = 16'h3CA5;
    bus_b.BRIGHT  = 4'hF;
    exp_tab       = TabOld;
    n             = 0;

    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset");
    rst = 1'b0;

    // Two frames of old data; DATA changes while group 2 is lit and must not show until frame 3.
    repeat (26) step();
    bus_a.DATA = DataNew;
    repeat (11) step();
    exp_tab = TabNew;
    repeat (13) step();

    // Reset while group 4 is in DRIVE, then restart and recapture.
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_reset("midreset");
    rst        = 1'b0;
    n          = 0;
    bus_a.DATA = DataOld;
    exp_tab    = TabOld;
    repeat (20) step();

    // Brightness: gates PLED only when dimming is built in, otherwise ignored.
    bright       = 4'd4;
    bus_a.BRIGHT = bright;
    repeat (36) step();
    bright       = 4'd0;
    bus_a.BRIGHT = bright;
    repeat (18) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
